// File: rtl/fft8_input_loader.sv
// rtl/fft8_input_loader.sv - ping-pong serial-to-parallel sample loader feeding the 8-point first butterfly stage
// Optional: FFT8_INPUT_SCALE_EN halves each component (arithmetic shift) before storage.
module fft8_input_loader #(
  parameter int DATA_W = 16,
  parameter int N_PTS  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sof,
  input  logic [DATA_W-1:0]         in_real,
  input  logic [DATA_W-1:0]         in_im,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_PTS*DATA_W-1:0]   out_real,
  output logic [N_PTS*DATA_W-1:0]   out_im,
  output logic                      err_sof
);

  localparam int IDX_W = $clog2(N_PTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);

  logic [DATA_W-1:0] real_q [2][N_PTS];
  logic [DATA_W-1:0] real_d [2][N_PTS];
  logic [DATA_W-1:0] im_q   [2][N_PTS];
  logic [DATA_W-1:0] im_d   [2][N_PTS];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              err_sof_q, err_sof_d;

  logic              accept;
  logic              handshake;
  logic              resync;
  logic [DATA_W-1:0] real_s;
  logic [DATA_W-1:0] im_s;

  function automatic logic [DATA_W-1:0] prescale(input logic [DATA_W-1:0] x);
`ifdef FFT8_INPUT_SCALE_EN
    return {x[DATA_W-1], x[DATA_W-1:1]};
`else
    return x;
`endif
  endfunction

  // Handshake flags depend only on registered state, never on in_valid/out_ready.
  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign err_sof   = err_sof_q;
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign resync    = in_sof && (wr_idx_q != '0);
  assign real_s    = prescale(in_real);
  assign im_s      = prescale(in_im);

  always_comb begin
    real_d    = real_q;
    im_d      = im_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    err_sof_d = 1'b0;

    // Completion and handshake can coincide; they always target different banks.
    if (handshake) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end

    if (accept) begin
      if (resync) begin
        real_d[wr_bank_q][0] = real_s;
        im_d[wr_bank_q][0]   = im_s;
        wr_idx_d             = IDX_W'(1);
        err_sof_d            = 1'b1;
      end else begin
        real_d[wr_bank_q][wr_idx_q] = real_s;
        im_d[wr_bank_q][wr_idx_q]   = im_s;
        if (wr_idx_q == LAST_IDX) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = !wr_bank_q;
          wr_idx_d          = '0;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_real = '0;
    out_im   = '0;
    for (int n = 0; n < N_PTS; n++) begin
      out_real[DATA_W*n +: DATA_W] = real_q[rd_bank_q][n];
      out_im[DATA_W*n +: DATA_W]   = im_q[rd_bank_q][n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int n = 0; n < N_PTS; n++) begin
          real_q[b][n] <= '0;
          im_q[b][n]   <= '0;
        end
      end
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      err_sof_q <= 1'b0;
    end else begin
      real_q    <= real_d;
      im_q      <= im_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      err_sof_q <= err_sof_d;
    end
  end

endmodule

// File: tb/tb_fft8_input_loader.sv
// tb/tb_fft8_input_loader.sv - directed and scoreboard checks for fft8_input_loader
module tb_fft8_input_loader;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_sof;
  logic [15:0]  in_real;
  logic [15:0]  in_im;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_real;
  logic [127:0] out_im;
  logic         err_sof;

  int checks = 0;
  int errors = 0;

  fft8_input_loader #(.DATA_W(16), .N_PTS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_real   (in_real),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_im    (out_im),
    .err_sof   (err_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] st(input logic [15:0] x);
`ifdef FFT8_INPUT_SCALE_EN
    return {x[15], x[15:1]};
`else
    return x;
`endif
  endfunction

  function automatic logic [127:0] pack_seq(input logic [15:0] base, input int first);
    logic [127:0] r;
    for (int s = 0; s < 8; s++) r[16*s +: 16] = st(16'(int'(base) + first + s));
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_real = '0; in_im = '0; out_ready = 1'b0;
    repeat (2) step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (err_sof !== 1'b0) begin errors++; $display("FAIL reset_err_sof: got %b expected 0", err_sof); end
    checks++; if (out_real !== '0) begin errors++; $display("FAIL reset_out_real: got %h expected 0", out_real); end
    checks++; if (out_im !== '0) begin errors++; $display("FAIL reset_out_im: got %h expected 0", out_im); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    logic [127:0] er, ei;
    int pulses = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      er[16*i +: 16] = st(16'(i + 1));
      ei[16*i +: 16] = st(16'(-(i + 1)));
    end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_real = 16'(i + 1); in_im = 16'(-(i + 1));
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready[%0d]: got %b expected 1", i, in_ready); end
      step();
      if (err_sof) pulses++;
      if (i < 7) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid[%0d]: got %b expected 0", i, out_valid); end
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid got %b expected 1", out_valid); end
    checks++; if (out_real !== er) begin errors++; $display("FAIL single_real: got %h expected %h", out_real, er); end
    checks++; if (out_im !== ei) begin errors++; $display("FAIL single_im: got %h expected %h", out_im, ei); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL single_err_sof: got %0d pulses expected 0", pulses); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_consumed: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int k;
    int got;
    int cyc;
    out_ready = 1'b0;
    for (k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_sof = ((k % 8) == 0); in_real = 16'(16'h1000 + k); in_im = 16'(16'h2000 + k);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 1", k, in_ready); end
      step();
    end
    in_valid = 1'b1; in_sof = 1'b0; in_real = 16'h1010; in_im = 16'h2010;
    for (int h = 0; h < 3; h++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall[%0d]: in_ready got %b expected 0", h, in_ready); end
      checks++; if (out_real !== pack_seq(16'h1000, 0)) begin errors++; $display("FAIL bp_stable[%0d]: got %h expected %h", h, out_real, pack_seq(16'h1000, 0)); end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_reenable: in_ready got %b expected 1", in_ready); end
    checks++; if (out_real !== pack_seq(16'h1000, 8)) begin errors++; $display("FAIL bp_frame1_real: got %h expected %h", out_real, pack_seq(16'h1000, 8)); end
    got = 1; cyc = 0;
    while (got < 3 && cyc < 200) begin
      in_valid = (k < 24); in_real = 16'(16'h1000 + k); in_im = 16'(16'h2000 + k); in_sof = ((k % 8) == 0);
      if (out_valid && out_ready) begin
        checks++; if (out_real !== pack_seq(16'h1000, 8*got)) begin errors++; $display("FAIL bp_order_real[%0d]: got %h expected %h", got, out_real, pack_seq(16'h1000, 8*got)); end
        checks++; if (out_im !== pack_seq(16'h2000, 8*got)) begin errors++; $display("FAIL bp_order_im[%0d]: got %h expected %h", got, out_im, pack_seq(16'h2000, 8*got)); end
        got++;
      end
      if (in_valid && in_ready) k++;
      step();
      cyc++;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    checks++; if (got != 3) begin errors++; $display("FAIL bp_frames: got %0d frames expected 3", got); end
    checks++; if (k != 24) begin errors++; $display("FAIL bp_accepts: got %0d samples expected 24", k); end
  endtask

  task automatic test_resync();
    int pulses = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_real = 16'(16'h00A0 + i); in_im = 16'(16'h00B0 + i);
      step();
      if (err_sof) pulses++;
    end
    in_sof = 1'b1; in_real = 16'h0100; in_im = 16'h0200;
    step();
    if (err_sof) pulses++;
    checks++; if (err_sof !== 1'b1) begin errors++; $display("FAIL resync_pulse: err_sof got %b expected 1", err_sof); end
    in_sof = 1'b0;
    for (int j = 1; j < 8; j++) begin
      in_real = 16'(16'h0100 + j); in_im = 16'(16'h0200 + j);
      step();
      if (err_sof) pulses++;
    end
    in_valid = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL resync_pulse_count: got %0d expected 1", pulses); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL resync_valid: got %b expected 1", out_valid); end
    checks++; if (out_real !== pack_seq(16'h0100, 0)) begin errors++; $display("FAIL resync_real: got %h expected %h", out_real, pack_seq(16'h0100, 0)); end
    checks++; if (out_im !== pack_seq(16'h0200, 0)) begin errors++; $display("FAIL resync_im: got %h expected %h", out_im, pack_seq(16'h0200, 0)); end
    step();
  endtask

  task automatic test_random();
    logic [127:0] qr[$];
    logic [127:0] qi[$];
    logic [127:0] cr, ci, xr, xi;
    int cnt = 0;
    int done = 0;
    int got = 0;
    int cyc = 0;
    int pending;
    cr = '0; ci = '0;
    while (got < 100 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 1) == 1) && (done < 100);
      in_real   = 16'($urandom);
      in_im     = 16'($urandom);
      in_sof    = (cnt == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      pending   = done - got;
      checks++; if (in_ready !== (pending < 2)) begin errors++; $display("FAIL rand_in_ready[cyc %0d]: got %b expected %b", cyc, in_ready, pending < 2); end
      checks++; if (out_valid !== (pending > 0)) begin errors++; $display("FAIL rand_out_valid[cyc %0d]: got %b expected %b", cyc, out_valid, pending > 0); end
      if (out_valid && out_ready) begin
        checks++;
        if (qr.size() == 0) begin
          errors++; $display("FAIL rand_extra_frame[cyc %0d]: got frame expected none", cyc);
        end else begin
          xr = qr.pop_front(); xi = qi.pop_front();
          if (out_real !== xr || out_im !== xi) begin
            errors++; $display("FAIL rand_frame[%0d]: got %h/%h expected %h/%h", got, out_real, out_im, xr, xi);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        cr[16*cnt +: 16] = st(in_real);
        ci[16*cnt +: 16] = st(in_im);
        cnt++;
        if (cnt == 8) begin
          qr.push_back(cr); qi.push_back(ci);
          cnt = 0; done++;
        end
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    checks++; if (got != 100) begin errors++; $display("FAIL rand_frame_count: got %0d expected 100", got); end
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b0;
    for (int k = 0; k < 13; k++) begin
      in_valid = 1'b1; in_sof = ((k % 8) == 0); in_real = 16'(16'h3000 + k); in_im = 16'(16'h4000 + k);
      step();
    end
    in_valid = 1'b0; in_sof = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending: out_valid got %b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_real !== '0 || out_im !== '0) begin errors++; $display("FAIL rstmid_data: got %h/%h expected 0/0", out_real, out_im); end
    step();
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_sof = (k == 0); in_real = 16'(16'h5000 + k); in_im = 16'(16'h6000 + k);
      step();
    end
    in_valid = 1'b0; in_sof = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_clean_valid: got %b expected 1", out_valid); end
    checks++; if (out_real !== pack_seq(16'h5000, 0)) begin errors++; $display("FAIL rstmid_clean_real: got %h expected %h", out_real, pack_seq(16'h5000, 0)); end
    checks++; if (out_im !== pack_seq(16'h6000, 0)) begin errors++; $display("FAIL rstmid_clean_im: got %h expected %h", out_im, pack_seq(16'h6000, 0)); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_consumed: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_scale();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sof = (i == 0);
      in_real  = (i == 0) ? 16'h8001 : 16'h0003;
      in_im    = (i == 0) ? 16'h7FFF : 16'hFFFC;
      step();
    end
    in_valid = 1'b0; in_sof = 1'b0;
    checks++; if (out_real[15:0] !== st(16'h8001)) begin errors++; $display("FAIL scale_real0: got %h expected %h", out_real[15:0], st(16'h8001)); end
    checks++; if (out_im[15:0] !== st(16'h7FFF)) begin errors++; $display("FAIL scale_im0: got %h expected %h", out_im[15:0], st(16'h7FFF)); end
    checks++; if (out_real[31:16] !== st(16'h0003)) begin errors++; $display("FAIL scale_real1: got %h expected %h", out_real[31:16], st(16'h0003)); end
    checks++; if (out_im[31:16] !== st(16'hFFFC)) begin errors++; $display("FAIL scale_im1: got %h expected %h", out_im[31:16], st(16'hFFFC)); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_resync();
    test_random();
    test_reset_mid_frame();
    test_scale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
